// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit for the EX stage.
//
// Takes the same forwarded operands as the ALU and produces a 2*WIDTH-bit
// product, or a quotient and remainder, in HI/LO. Every operation takes a
// fixed WIDTH+1 cycles after the launch edge, whatever the data. busy_o
// stalls the pipeline through the hazard unit.
//
// Ports:
//   clk_i    - clock; all state changes on the rising edge
//   rst_i    - synchronous, active-high reset; overrides everything
//   start_i  - launch an operation; only looked at in IDLE
//   flush_i  - synchronous abort; wins over start_i and over a running op
//   op_i     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1_i  - operand A (multiplicand / dividend), forwarded rs
//   data2_i  - operand B (multiplier / divisor), forwarded rt/imm
//   busy_o   - high while an operation is in flight
//   done_o   - one-cycle pulse: HI/LO were written at the previous edge
//   hi_o     - HI register (upper half of product / remainder)
//   lo_o     - LO register (lower half of product / quotient)
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [CW-1:0]      CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LAST  = {CW{1'b1}} >> (CW - $clog2(WIDTH));
    localparam logic [WIDTH-1:0]   ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]     ZERO_W1   = {(WIDTH+1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    // Two's-complement negation at operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + ONE_W;
    endfunction

    // Two's-complement negation at product width.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        neg_2w = ~v + ONE_2W;
    endfunction

    // Absolute value when the operand is a negative signed value, raw otherwise.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_neg);
        magnitude = is_neg ? neg_w(v) : v;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               is_div_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [WIDTH-1:0]   raw_a_r;
    // rem_r is the running high half (product) or partial remainder (divide);
    // quo_r starts as |A| and shifts into the low half / quotient.
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [CW-1:0]      cnt_r;

    logic               launch_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [WIDTH-1:0]   rem_step_s;
    logic [WIDTH-1:0]   quo_step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fin_hi_s;
    logic [WIDTH-1:0]   fin_lo_s;

    assign launch_s = (state_r == ST_IDLE) && start_i && !flush_i;
    // op_i[0]=0 selects the signed variants.
    assign neg_a_s  = ~op_i[0] & data1_i[WIDTH-1];
    assign neg_b_s  = ~op_i[0] & data2_i[WIDTH-1];

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign hi_o   = hi_r;
    assign lo_o   = lo_r;

    // State register; busy is registered from the next state so it tracks state exactly
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Next-state decode: flush aborts CALC/FIN, the last CALC step moves to FIN
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_FIN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum_s   = {1'b0, rem_r} + (quo_r[0] ? {1'b0, mag_b_r} : ZERO_W1);
        div_shift_s = {rem_r, quo_r[WIDTH-1]};
        // Top bit set means the trial subtraction borrowed (partial < divisor).
        div_diff_s  = div_shift_s - {1'b0, mag_b_r};
        rem_step_s  = rem_r;
        quo_step_s  = quo_r;
        if (is_div_r) begin
            if (!div_diff_s[WIDTH]) begin
                rem_step_s = div_diff_s[WIDTH-1:0];
                quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_step_s = div_shift_s[WIDTH-1:0];
                quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            rem_step_s = mul_sum_s[WIDTH:1];
            quo_step_s = {mul_sum_s[0], quo_r[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied when leaving FIN
    always_comb begin
        prod_s   = {rem_r, quo_r};
        fin_hi_s = hi_r;
        fin_lo_s = lo_r;
        if (is_div_r) begin
            if (mag_b_r == ZERO_W) begin
                // Divide by zero: all-ones quotient, dividend passed through untouched.
                fin_hi_s = raw_a_r;
                fin_lo_s = ONES_W;
            end else begin
                fin_lo_s = (sign_a_r ^ sign_b_r) ? neg_w(quo_r) : quo_r;
                fin_hi_s = sign_a_r ? neg_w(rem_r) : rem_r;
            end
        end else begin
            if (sign_a_r ^ sign_b_r) begin
                prod_s = neg_2w({rem_r, quo_r});
            end else begin
                prod_s = {rem_r, quo_r};
            end
            fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fin_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Operand capture at launch, iteration in CALC, HI/LO write-back and done pulse in FIN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_div_r <= 1'b0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            mag_b_r  <= ZERO_W;
            raw_a_r  <= ZERO_W;
            rem_r    <= ZERO_W;
            quo_r    <= ZERO_W;
            cnt_r    <= CNT_ZERO;
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        is_div_r <= op_i[1];
                        sign_a_r <= neg_a_s;
                        sign_b_r <= neg_b_s;
                        quo_r    <= magnitude(data1_i, neg_a_s);
                        mag_b_r  <= magnitude(data2_i, neg_b_s);
                        raw_a_r  <= data1_i;
                        rem_r    <= ZERO_W;
                        cnt_r    <= CNT_ZERO;
                    end
                end
                ST_CALC: begin
                    if (!flush_i) begin
                        rem_r <= rem_step_s;
                        quo_r <= quo_step_s;
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_FIN: begin
                    if (!flush_i) begin
                        hi_r   <= fin_hi_s;
                        lo_r   <= fin_lo_s;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          flush_i;
    logic [1:0]    op_i;
    logic [W-1:0]  data1_i;
    logic [W-1:0]  data2_i;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .flush_i (flush_i),
        .op_i    (op_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [W-1:0] last_hi = 32'h0;
    logic [W-1:0] last_lo = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sbv, q, r;
        case (op)
            2'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); model = sp; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; model = up; end
            2'd2: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
                else begin
                    sa = a; sbv = b; q = sa / sbv; r = sa % sbv;
                    model = {r, q};
                end
            end
            default: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else model = {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'h0;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h8000_0000;
            3: pick = $urandom_range(0, 20);
            default: pick = $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expectation, value and cycle.
    always @(negedge clk) begin
        if (done_o) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done_o=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("hi", 64'(hi_o), 64'(mon_e.hi));
                check("lo", 64'(lo_o), 64'(mon_e.lo));
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                last_hi = mon_e.hi;
                last_lo = mon_e.lo;
            end
        end
    end

    // Call at a negedge with the unit idle (or in its done cycle); returns at the done negedge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit noise);
        int bc;
        bit seen;
        op_i = op; data1_i = a; data2_i = b; start_i = 1'b1;
        sbq.push_back('{eh, el, cyc + 1 + LAT});
        @(negedge clk);
        start_i = 1'b0;
        bc = busy_o ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (busy_o) bc++;
                if (bc == LAT) begin
                    check("hold_hi", 64'(hi_o), 64'(last_hi));
                    check("hold_lo", 64'(lo_o), 64'(last_lo));
                end
                if (noise && bc == 10) begin
                    start_i = 1'b1; op_i = 2'($urandom); data1_i = $urandom; data2_i = $urandom;
                end else begin
                    start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no done_o expected one within 100 cycles");
        end
        check("busy_cycles", 64'(bc), 64'(LAT));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] m;
        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'd0; data1_i = 32'h0; data2_i = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // Directed cases, issued back-to-back in each done cycle.
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(2'd0, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op(2'd3, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);

        // Flush mid-operation with an ignored start in between.
        @(negedge clk);
        op_i = 2'd1; data1_i = 32'd5; data2_i = 32'd6; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        op_i = 2'd2; data1_i = 32'd77; data2_i = 32'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_during_calc", 64'(busy_o), 64'd1);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_done", 64'(done_o), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_keep_hi", 64'(hi_o), 64'h0000_1234);
        check("flush_keep_lo", 64'(lo_o), 64'hFFFF_FFFF);
        run_op(2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        op_i = 2'd1; data1_i = 32'hFFFF_FFFF; data2_i = 32'h1234_5678; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_done", 64'(done_o), 64'd0);
        check("midrst_hi", 64'(hi_o), 64'd0);
        check("midrst_lo", 64'(lo_o), 64'd0);
        rst_i = 1'b0;
        last_hi = 32'h0;
        last_lo = 32'h0;

        // start together with flush in IDLE must not launch.
        op_i = 2'd3; data1_i = 32'd9; data2_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        check("sf_busy1", 64'(busy_o), 64'd0);
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("sf_busy2", 64'(busy_o), 64'd0);
        check("sf_lo", 64'(lo_o), 64'd0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            m   = model(rop, ra, rb);
            run_op(rop, ra, rb, m[63:32], m[31:0], ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage. It consumes the same forwarded operands that feed the ALU: rs from the forwarding mux, and rt/immediate from the ALUSrc-qualified forwarding mux. It computes 64-bit products and quotient/remainder over WIDTH cycles and holds the results in HI/LO registers. busy_o drives the hazard unit's stall.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  reset, synchronous, active-high
start_i  input  1  launch an operation; sampled only in IDLE
flush_i  input  1  synchronous abort from pipeline control
op_i  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
data1_i  input  WIDTH  operand A (multiplicand / dividend), forwarded rs
data2_i  input  WIDTH  operand B (multiplier / divisor), forwarded rt/imm
busy_o  output  1  high while state != IDLE
done_o  output  1  registered one-cycle pulse: HI/LO just updated
hi_o  output  WIDTH  HI register (product upper half / remainder)
lo_o  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, counter=0, hi_o=0, lo_o=0, done_o=0, busy_o=0. Reset has priority over everything, including mid-operation; no partial result reaches HI/LO.
- States:
  - IDLE: on an edge with start_i=1 and flush_i=0, latch op_i, record operand signs, and latch magnitudes. Magnitude is the absolute value for signed ops and the raw value for unsigned ops. Set counter=0 and go to CALC.
  - CALC: one radix-2 step per edge. Multiply uses shift-add. Divide uses restoring shift-subtract on the unsigned magnitudes. Counter increments each step. The edge performing step WIDTH-1 moves to FIN.
  - FIN: on the next edge, apply sign correction, write hi_o/lo_o, set done_o=1 for exactly the following cycle, and return to IDLE.
- Latency: start accepted at edge k; CALC steps at edges k+1..k+WIDTH; HI/LO written at edge k+WIDTH+1 (k+33 for WIDTH=32). done_o is high during the cycle after that edge. busy_o is high from after edge k through edge k+WIDTH+1. Latency is fixed and data-independent.
- Signs:
  - MULT: product negated (2·WIDTH-bit two's complement) when signA^signB.
  - DIV: quotient negated when signA^signB; remainder takes sign of dividend.
  - Unsigned ops: no correction.
- Boundary: DIV of -2^(WIDTH-1) by -1 gives lo=0x80000000, hi=0 (wraps, no trap).
- Boundary: divide by zero (DIV or DIVU) runs full latency, then lo=all ones and hi=raw data1_i as latched. No sign correction is applied.
- start_i while busy: ignored; operands and op are not re-latched.
- flush_i=1 at an edge in CALC or FIN: return to IDLE; HI/LO unchanged; done_o stays 0.
- flush_i=1 together with start_i in IDLE: flush wins; no launch.
- done_o is 0 in all cycles other than the single post-FIN cycle. Back-to-back start_i during the done_o cycle is accepted (state is IDLE).
- HI/LO hold their values indefinitely between operations.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at edge k -> busy_o high 33 cycles; done_o pulse after edge k+33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7 × 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234 after full 33 cycles.
- Start MULTU 5×6; pulse start_i with different operands at cycle 10; assert flush_i at cycle 20 -> busy_o drops next cycle, no done_o, HI/LO keep the prior values. A fresh start then completes normally with hi=0, lo=30.
- Assert rst_i mid-CALC -> next cycle busy_o=0, done_o=0, hi_o=lo_o=0. start_i+flush_i together in IDLE -> busy_o stays 0.
- Issue a new start_i in the done_o cycle -> accepted. The second result appears exactly 33 cycles later; the first result stays visible on HI/LO until then.
